// File: rtl/serial_mem_server.sv
// serial_mem_server
//   Bit-serial memory server for the bit-serial CPU. The CPU shifts in a
//   frame one bit per valid cycle, MSB first:
//     op (1 = write, 0 = read), ADDR_W address bits, then DATA_W data bits
//     (writes only).
//   A read returns the addressed word MSB first on ser_out_* after TURN_CYC
//   idle cycles. A write commits on the edge that takes its last data bit.
//   A parallel preload port fills the memory while the server is idle.
//
// Ports
//   sys_clk, sys_reset_n   : clock (rising edge), async active-low reset
//   ser_in_valid/_bit      : serial frame input
//   ser_out_valid/_bit     : serial read data, DATA_W consecutive cycles
//   wr_ack                 : one-cycle pulse after a write commits
//   err                    : one-cycle pulse on range or protocol error
//   busy                   : high whenever a frame is in progress
//   load_en/addr/data      : preload strobe, honoured only when idle
//
// ADDR_W and DATA_W must both be at least 2.
module serial_mem_server #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              ser_in_valid,
  input  logic              ser_in_bit,
  output logic              ser_out_valid,
  output logic              ser_out_bit,
  output logic              wr_ack,
  output logic              err,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_TURN,
    S_TX
  } state_t;

  // One down-counter serves every phase, so size it for the longest one.
  localparam int unsigned AD_MAX  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_MAX = (AD_MAX > TURN_CYC) ? AD_MAX : TURN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   out_sh_q, out_sh_d;
  logic                tx_fresh_q, tx_fresh_d;
  logic                wr_ack_q, wr_ack_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr_shift;
  logic [DATA_W-1:0]   data_shift;
  logic [DATA_W-1:0]   tx_word;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign addr_shift = {addr_q[ADDR_W-2:0], ser_in_bit};
  assign data_shift = {data_q[DATA_W-2:0], ser_in_bit};

  // The RAM word only arrives on the first TX cycle (registered read), so that
  // cycle takes its bits straight from the RAM output; later cycles use the
  // shift register. Out-of-range reads stream zeros.
  assign tx_word = tx_fresh_q ? (in_range(addr_q) ? mem_rdata_q : '0) : out_sh_q;

  // Storage: single write port (preload or frame write), registered read.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    mem_rdata_q <= mem[mem_raddr];
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      out_sh_q   <= '0;
      tx_fresh_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      out_sh_q   <= out_sh_d;
      tx_fresh_q <= tx_fresh_d;
      wr_ack_q   <= wr_ack_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    out_sh_d   = out_sh_q;
    tx_fresh_d = 1'b0;
    wr_ack_d   = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = data_shift;
    mem_raddr  = addr_q;

    case (state_q)
      S_IDLE: begin
        if (ser_in_valid) begin
          op_d    = ser_in_bit;
          cnt_d   = CNT_W'(ADDR_W - 1);
          state_d = S_RX_ADDR;
        end
        if (load_en) begin
          if (in_range(load_addr)) begin
            mem_we    = 1'b1;
            mem_waddr = load_addr;
            mem_wdata = load_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RX_ADDR: begin
        if (!ser_in_valid) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d = addr_shift;
          if (cnt_q == '0) begin
            if (op_q) begin
              cnt_d   = CNT_W'(DATA_W - 1);
              state_d = S_RX_DATA;
            end else begin
              // Start the RAM read with the address as it completes, so a
              // zero-turnaround read has its word on the first TX cycle.
              mem_raddr = addr_shift;
              if (TURN_CYC == 0) begin
                cnt_d      = CNT_W'(DATA_W - 1);
                tx_fresh_d = 1'b1;
                err_d      = !in_range(addr_shift);
                state_d    = S_TX;
              end else begin
                cnt_d   = CNT_W'(TURN_CYC - 1);
                state_d = S_TURN;
              end
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_RX_DATA: begin
        if (!ser_in_valid) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          data_d = data_shift;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            if (in_range(addr_q)) begin
              mem_we   = 1'b1;
              wr_ack_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_TURN: begin
        err_d = ser_in_valid;
        if (cnt_q == '0) begin
          cnt_d      = CNT_W'(DATA_W - 1);
          tx_fresh_d = 1'b1;
          err_d      = ser_in_valid | !in_range(addr_q);
          state_d    = S_TX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_TX: begin
        err_d    = ser_in_valid;
        out_sh_d = tx_word << 1;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ser_out_valid = (state_q == S_TX);
    ser_out_bit   = (state_q == S_TX) & tx_word[DATA_W-1];
    wr_ack        = wr_ack_q;
    err           = err_q;
    busy          = (state_q != S_IDLE);
  end

endmodule

// File: doc/serial_mem_server.md
Name: serial_mem_server

Overview:
- Synthesizable bit-serial memory server for the bit-serial CPU; replaces behavioural instruction and micro-instruction memories.
- CPU shifts in a command frame (op bit, address, optional write data) one bit per clock, MSB first. The block then shifts back the addressed word MSB first, or stores the write data.
- Parametrised in address width, data width, depth and turnaround latency, so one block serves both the instruction path (10/16) and the micro-instruction path (9/MINST_WIDTH).
- Adds writes, a parallel preload port, and range/protocol error reporting.

Parameters:
- ADDR_W, 10, address bits per frame
- DATA_W, 16, word width
- DEPTH, 1024, words stored; 1 ≤ DEPTH ≤ 2^ADDR_W
- TURN_CYC, 1, idle cycles between last address bit and first data bit of a read; 0..15

Ports:
- sys_clk  in  1  clock, all state on rising edge
- sys_reset_n  in  1  asynchronous active-low reset
- ser_in_valid  in  1  ser_in_bit carries a frame bit this cycle
- ser_in_bit  in  1  serial frame bit from CPU
- ser_out_valid  out  1  ser_out_bit carries a read-data bit this cycle
- ser_out_bit  out  1  serial read data, MSB first
- wr_ack  out  1  one-cycle pulse when a write commits
- err  out  1  one-cycle pulse on a range or protocol error
- busy  out  1  high in any state other than IDLE
- load_en  in  1  parallel preload strobe; honoured only when busy=0
- load_addr  in  ADDR_W  preload address
- load_data  in  DATA_W  preload word

Behaviour:
- Reset (async assert, sync release): state=IDLE; bit counter=0; shift registers=0; ser_out_valid=0, ser_out_bit=0, wr_ack=0, err=0, busy=0. Memory contents are not reset.
- Frame format: bit0 = op (1 write, 0 read), then ADDR_W address bits MSB first, then DATA_W data bits MSB first for writes only. Bits are sampled only on edges where ser_in_valid=1.
- IDLE:
  - ser_in_valid=1 → latch op, go to RX_ADDR with counter=ADDR_W-1.
  - load_en=1 with load_addr<DEPTH → mem[load_addr]<=load_data.
  - load_en=1 with load_addr≥DEPTH → err pulse, no write.
  - load_en while busy=1 is ignored with no err.
- RX_ADDR: shift in one bit per valid cycle. ser_in_valid=0 mid-frame → err pulse, discard, IDLE. After the last address bit: read → TURN (or directly TX if TURN_CYC=0); write → RX_DATA.
- RX_DATA: shift DATA_W bits; ser_in_valid gap → err, IDLE, no write. After the last bit:
  - address<DEPTH → mem write commits on that edge; wr_ack=1 next cycle.
  - address≥DEPTH → err=1 next cycle instead; no write.
  - Return to IDLE.
- TURN: count TURN_CYC cycles, then load the output shift register with mem[addr] (or 0 with an err pulse if addr≥DEPTH), go to TX.
- TX: ser_out_valid=1 for exactly DATA_W consecutive cycles, MSB first, then IDLE.
  - ser_in_valid=1 in TURN/TX → err pulse; input ignored; transfer continues.
  - First output bit appears ADDR_W+1+TURN_CYC cycles after the op bit.
- Back-to-back: a new op bit is accepted in the cycle after wr_ack, or the cycle after the last TX bit.
- Mid-operation reset: immediate return to reset values; partial frames discarded, no memory write.
- err and wr_ack are never high in the same cycle.

Test Plan:
- Preload mem[0x005]=0xA5C3; read frame op=0, addr=0000000101 → after 1 turn cycle, ser_out emits 1010010111000011 over 16 valid cycles; err=0, busy falls afterwards.
- Write frame op=1, addr=0x3FF, data=0x1234 → wr_ack pulse one cycle after last bit. Following read of 0x3FF returns 0x1234.
- DEPTH=160, ADDR_W=9: read addr=200 → err pulse; ser_out emits 16 zeros; no memory change.
- ser_in_valid dropped after 4 address bits → err pulse, busy=0 next cycle. Next full read of addr 0x005 returns 0xA5C3.
- sys_reset_n pulled low during TX bit 7 → ser_out_valid=0 immediately. Memory retained: re-read returns the same word.
- TURN_CYC=0 and 3 variants: first ser_out_valid exactly 11 and 14 cycles after the op bit (ADDR_W=10). ser_in_valid pulsed during TX → err pulse, data stream unaffected.
